// File: rtl/pln_dmem_ctrl_pkg.sv
// Shared types and memory-map constants for the PLN data-memory controller.
// Offsets and STATUS bit positions match the map used by the CPU firmware tests.
package pln_dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef enum logic [2:0] {
        TGT_RAM,
        TGT_CON,
        TGT_STAT,
        TGT_CYC,
        TGT_NONE
    } target_e;

    localparam logic [15:0] OFS_CON_DATA = 16'h0000;
    localparam logic [15:0] OFS_STATUS   = 16'h0001;
    localparam logic [15:0] OFS_CYCLES   = 16'h0002;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 4;

    function automatic logic [3:0] sat_count(input logic [15:0] cnt);
        return (cnt > 16'd15) ? 4'hF : cnt[3:0];
    endfunction

    function automatic logic [15:0] pack_status(input logic [3:0] cnt, input logic ovf,
                                                input logic empty, input logic full);
        logic [15:0] s;
        s = '0;
        s[STAT_CNT_LSB +: 4] = cnt;
        s[STAT_OVF]          = ovf;
        s[STAT_EMPTY]        = empty;
        s[STAT_FULL]         = full;
        return s;
    endfunction

endpackage

// File: rtl/pln_dmem_ctrl_if.sv
// CPU data-port bundle between the PLN memory stage (master) and the controller (slave).
// req/write/addr/wdata are sampled only while the controller is idle; every accepted
// req gets exactly one ready pulse, and rdata/bus_err are meaningful only while ready=1.
interface pln_dmem_ctrl_if;
    logic        req;
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ready;
    logic        bus_err;

    modport master (output req, write, addr, wdata, input rdata, ready, bus_err);
    modport slave  (input req, write, addr, wdata, output rdata, ready, bus_err);
endinterface

// File: rtl/pln_dmem_ctrl_fifo.sv
// Console TX FIFO, registered output (no fall-through).
// A push into a full FIFO is still accepted when a pop happens on the same edge.
module pln_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    wr_q;
    logic [AW:0]      cnt_q;
    logic             do_pop;
    logic             do_push;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign count_o = cnt_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_pop)  rd_q <= rd_q + AW'(1);
            if (do_push) wr_q <= wr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset; dout is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/pln_dmem_ctrl.sv
// PLN CPU data-memory controller: fixed 3-cycle accesses to sync RAM, the console
// FIFO, STATUS and a free-running cycle counter; unmapped accesses pulse bus_err.
module pln_dmem_ctrl
    import pln_dmem_ctrl_pkg::*;
#(
    parameter int          RAM_AW     = 12,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] MMIO_BASE  = 16'hFF00
) (
    input  logic              clk,
    input  logic              rst,
    pln_dmem_ctrl_if.slave    cpu,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [15:0]       ram_wdata_o,
    input  logic [15:0]       ram_rdata_i,
    output logic              con_valid_o,
    output logic [7:0]        con_data_o,
    input  logic              con_ready_i,
    output state_e            state_o
);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [16:0] RAM_WORDS = 17'd1 << RAM_AW;

    state_e              state_q, state_d;
    target_e             tgt_q, tgt_d, req_tgt;
    logic                write_q, write_d;
    logic [7:0]          byte_q, byte_d;
    logic [15:0]         rdata_q, rdata_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;
    logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
    logic [15:0]         ram_wdata_q, ram_wdata_d;
    logic                ovf_q, ovf_d;
    logic [15:0]         cyc_q;
    logic [15:0]         offset;
    logic                fifo_push, fifo_pop, fifo_full, fifo_empty, ovf_clr;
    logic [CW-1:0]       fifo_count;
    logic [15:0]         status;

    pln_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_con_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (byte_q),
        .dout_o  (con_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign con_valid_o = !fifo_empty;
    assign fifo_pop    = con_valid_o && con_ready_i;
    assign status      = pack_status(sat_count(16'(fifo_count)), ovf_q, fifo_empty, fifo_full);

    // MMIO wins over RAM so a large RAM_AW can never shadow the register window.
    always_comb begin
        req_tgt = TGT_NONE;
        offset  = cpu.addr - MMIO_BASE;
        if (cpu.addr >= MMIO_BASE) begin
            case (offset)
                OFS_CON_DATA: req_tgt = TGT_CON;
                OFS_STATUS:   req_tgt = TGT_STAT;
                OFS_CYCLES:   req_tgt = TGT_CYC;
                default:      req_tgt = TGT_NONE;
            endcase
        end else if ({1'b0, cpu.addr} < RAM_WORDS) begin
            req_tgt = TGT_RAM;
        end
    end

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        write_d     = write_q;
        byte_d      = byte_q;
        rdata_d     = rdata_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        fifo_push   = 1'b0;
        ovf_clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu.req) begin
                    state_d = ST_ISSUE;
                    tgt_d   = req_tgt;
                    write_d = cpu.write;
                    byte_d  = cpu.wdata[7:0];
                    if (req_tgt == TGT_RAM) begin
                        ram_en_d    = 1'b1;
                        ram_we_d    = cpu.write;
                        ram_addr_d  = cpu.addr[RAM_AW-1:0];
                        ram_wdata_d = cpu.wdata;
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                state_d = ST_RESP;
                rdata_d = '0;
                case (tgt_q)
                    TGT_RAM:  if (!write_q) rdata_d = ram_rdata_i;
                    TGT_CON:  fifo_push = write_q;
                    TGT_STAT: begin
                        if (!write_q) rdata_d = status;
                        ovf_clr = write_q && byte_q[STAT_OVF];
                    end
                    TGT_CYC:  if (!write_q) rdata_d = cyc_q;
                    default:  rdata_d = '0;
                endcase
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A push that lands on a full FIFO with no pop on the same edge is lost.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tgt_q       <= TGT_NONE;
            write_q     <= 1'b0;
            byte_q      <= '0;
            rdata_q     <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ovf_q       <= 1'b0;
            cyc_q       <= '0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            write_q     <= write_d;
            byte_q      <= byte_d;
            rdata_q     <= rdata_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ovf_q       <= ovf_d;
            cyc_q       <= cyc_q + 16'd1;
        end
    end

    assign cpu.ready   = (state_q == ST_RESP);
    assign cpu.bus_err = cpu.ready && (tgt_q == TGT_NONE);
    assign cpu.rdata   = cpu.ready ? rdata_q : '0;

    assign ram_en_o    = ram_en_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pln_dmem_ctrl.sv
// Bench for pln_dmem_ctrl: sync RAM fixture, queue-based console model, per-feature tasks.
module tb_pln_dmem_ctrl;
    import pln_dmem_ctrl_pkg::*;

    localparam int          RAM_AW     = 12;
    localparam int          FIFO_DEPTH = 8;
    localparam logic [15:0] MMIO_BASE  = 16'hFF00;
    localparam logic [15:0] A_CON      = 16'hFF00;
    localparam logic [15:0] A_STAT     = 16'hFF01;
    localparam logic [15:0] A_CYC      = 16'hFF02;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ram_en, ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [15:0]       ram_wdata;
    logic [15:0]       ram_rdata = '0;
    logic              con_valid;
    logic [7:0]        con_data;
    logic              con_ready = 1'b0;
    state_e            dbg_state;

    pln_dmem_ctrl_if cpu_if();

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] ref_mem [0:4095];
    logic [15:0] tb_ram  [0:4095];
    logic [7:0]  fq [$];
    logic        ovf_m  = 1'b0;
    int          tb_cyc = 0;
    int          pops   = 0;

    always #5 clk = ~clk;

    pln_dmem_ctrl #(.RAM_AW(RAM_AW), .FIFO_DEPTH(FIFO_DEPTH), .MMIO_BASE(MMIO_BASE)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu         (cpu_if),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata),
        .con_valid_o (con_valid),
        .con_data_o  (con_data),
        .con_ready_i (con_ready),
        .state_o     (dbg_state)
    );

    // Synchronous single-port RAM fixture.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) tb_ram[ram_addr] <= ram_wdata;
            else        ram_rdata <= tb_ram[ram_addr];
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) tb_cyc <= 0;
        else     tb_cyc <= tb_cyc + 1;
    end

    // Console consumer: every pop must deliver the oldest byte the model holds.
    always @(posedge clk) begin
        if (!rst && con_valid && con_ready) begin
            tests_run++;
            if (fq.size() == 0) begin
                tests_failed++;
                $display("FAIL con_pop_unexpected: got byte %h, expected no data", con_data);
            end else begin
                if (con_data !== fq[0]) begin
                    tests_failed++;
                    $display("FAIL con_data: got %h expected %h", con_data, fq[0]);
                end
                void'(fq.pop_front());
            end
            pops++;
        end
    end

    // ---------------- reference model ----------------
    function automatic int ref_kind(input logic [15:0] a);
        if (a >= MMIO_BASE) begin
            if (a == A_CON)  return 1;
            if (a == A_STAT) return 2;
            if (a == A_CYC)  return 3;
            return 4;
        end
        if (int'(a) < (1 << RAM_AW)) return 0;
        return 4;
    endfunction

    function automatic logic [15:0] ref_status();
        int n = fq.size();
        logic [3:0] c = (n > 15) ? 4'hF : 4'(n);
        return {8'h00, c, 1'b0, ovf_m, (n == 0), (n == FIFO_DEPTH)};
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        case (ref_kind(a))
            0:       return ref_mem[a[11:0]];
            2:       return ref_status();
            default: return 16'h0000;
        endcase
    endfunction

    task automatic ref_commit(input logic wr, input logic [15:0] a, input logic [15:0] wd);
        if (wr) begin
            case (ref_kind(a))
                0: ref_mem[a[11:0]] = wd;
                1: if (fq.size() < FIFO_DEPTH) fq.push_back(wd[7:0]); else ovf_m = 1'b1;
                2: if (wd[2]) ovf_m = 1'b0;
                default: ;
            endcase
        end
    endtask

    function automatic logic [63:0] out_vec();
        return {7'b0, cpu_if.rdata, cpu_if.ready, cpu_if.bus_err, ram_en, ram_we,
                ram_addr, ram_wdata, con_valid, con_data};
    endfunction

    // ---------------- drivers ----------------
    task automatic do_access(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                             output logic [15:0] rd, output logic err, output int lat,
                             output int en_cycles, output int c0);
        @(negedge clk);
        cpu_if.req = 1'b1; cpu_if.write = wr; cpu_if.addr = a; cpu_if.wdata = wd;
        rd = '0; err = 1'b0; en_cycles = 0;
        @(posedge clk); @(negedge clk);
        cpu_if.req = 1'b0;
        c0  = tb_cyc;
        lat = 1;
        if (ram_en) en_cycles++;
        while (!cpu_if.ready && lat < 10) begin
            @(posedge clk); @(negedge clk);
            lat++;
            if (ram_en) en_cycles++;
        end
        if (cpu_if.ready) begin
            rd  = cpu_if.rdata;
            err = cpu_if.bus_err;
        end
    endtask

    task automatic drain(output int cycles);
        @(negedge clk);
        con_ready = 1'b1;
        cycles = 0;
        while (con_valid && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        con_ready = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (out_vec() !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected %h", out_vec(), 64'h0);
        end
        tests_run++;
        if (dbg_state !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (cpu_if.ready !== 1'b0 || con_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: got ready=%b con_valid=%b expected 0 0", cpu_if.ready, con_valid);
        end
    endtask

    task automatic test_ram_rw();
        logic [15:0] rd; logic err; int lat, en, c0;
        do_access(1'b1, 16'h0010, 16'hBEEF, rd, err, lat, en, c0);
        ref_commit(1'b1, 16'h0010, 16'hBEEF);
        tests_run++;
        if (lat !== 3 || err !== 1'b0 || en !== 1) begin
            tests_failed++;
            $display("FAIL ram_write: got lat=%0d err=%b en=%0d expected 3 0 1", lat, err, en);
        end
        do_access(1'b0, 16'h0010, 16'h0000, rd, err, lat, en, c0);
        tests_run++;
        if (rd !== 16'hBEEF || lat !== 3 || err !== 1'b0 || en !== 1) begin
            tests_failed++;
            $display("FAIL ram_read: got rd=%h lat=%0d err=%b en=%0d expected BEEF 3 0 1", rd, lat, err, en);
        end
    endtask

    task automatic test_ram_random();
        logic [15:0] rd, a, wd, exp; logic err, wr; int lat, en, c0;
        for (int i = 0; i < 40; i++) begin
            wr  = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 7) == 0) ? 16'h0FFF : 16'($urandom_range(0, 31));
            wd  = 16'($urandom);
            exp = ref_read(a);
            do_access(wr, a, wd, rd, err, lat, en, c0);
            tests_run++;
            if (lat !== 3 || err !== 1'b0 || en !== 1) begin
                tests_failed++;
                $display("FAIL ram_rand_timing: addr=%h got lat=%0d err=%b en=%0d expected 3 0 1", a, lat, err, en);
            end
            if (!wr) begin
                tests_run++;
                if (rd !== exp) begin
                    tests_failed++;
                    $display("FAIL ram_rand_read: addr=%h got %h expected %h", a, rd, exp);
                end
            end
            ref_commit(wr, a, wd);
        end
    endtask

    task automatic test_unmapped();
        logic [15:0] tbl [5];
        logic [15:0] rd, exp; logic err; int lat, en, c0;
        tbl[0] = 16'h2000; tbl[1] = 16'h1000; tbl[2] = 16'hFE00; tbl[3] = 16'hFF03; tbl[4] = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            do_access(1'b0, tbl[i], 16'h0000, rd, err, lat, en, c0);
            tests_run++;
            if (rd !== 16'h0000 || err !== 1'b1 || en !== 0 || lat !== 3) begin
                tests_failed++;
                $display("FAIL unmapped_read: addr=%h got rd=%h err=%b en=%0d lat=%0d expected 0000 1 0 3",
                         tbl[i], rd, err, en, lat);
            end
        end
        do_access(1'b1, 16'h1000, 16'h1234, rd, err, lat, en, c0);
        tests_run++;
        if (err !== 1'b1 || en !== 0) begin
            tests_failed++;
            $display("FAIL unmapped_write: got err=%b en=%0d expected 1 0", err, en);
        end
        do_access(1'b1, 16'h2000, 16'h5678, rd, err, lat, en, c0);
        exp = ref_read(16'h0000);
        do_access(1'b0, 16'h0000, 16'h0000, rd, err, lat, en, c0);
        tests_run++;
        if (rd !== exp || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL unmapped_alias: got rd=%h err=%b expected %h 0", rd, err, exp);
        end
        do_access(1'b0, 16'h0FFF, 16'h0000, rd, err, lat, en, c0);
        tests_run++;
        if (rd !== ref_read(16'h0FFF) || err !== 1'b0 || en !== 1) begin
            tests_failed++;
            $display("FAIL ram_top_word: got rd=%h err=%b en=%0d expected %h 0 1", rd, err, en, ref_read(16'h0FFF));
        end
    endtask

    task automatic test_busy_ignore();
        logic [15:0] rdy_mask, en_mask, exp; int bad_rd;
        rdy_mask = '0; en_mask = '0; bad_rd = 0;
        exp = ref_read(16'h0010);
        @(negedge clk);
        cpu_if.req = 1'b1; cpu_if.write = 1'b0; cpu_if.addr = 16'h0010; cpu_if.wdata = 16'h0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); @(negedge clk);
            if (n == 6) cpu_if.req = 1'b0;
            rdy_mask[n] = cpu_if.ready;
            en_mask[n]  = ram_en;
            if (cpu_if.ready && cpu_if.rdata !== exp) bad_rd++;
        end
        tests_run++;
        if (rdy_mask !== 16'h0088) begin
            tests_failed++;
            $display("FAIL busy_ready_pulses: got mask %h expected %h", rdy_mask, 16'h0088);
        end
        tests_run++;
        if (en_mask !== 16'h0022) begin
            tests_failed++;
            $display("FAIL busy_ram_issues: got mask %h expected %h", en_mask, 16'h0022);
        end
        tests_run++;
        if (bad_rd !== 0) begin
            tests_failed++;
            $display("FAIL busy_rdata: got %0d bad reads expected 0", bad_rd);
        end
    endtask

    task automatic test_console();
        logic [15:0] rd; logic err; int lat, en, c0, bad_lat, p0, dc;
        bad_lat = 0;
        @(negedge clk); con_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            do_access(1'b1, A_CON, 16'h0041, rd, err, lat, en, c0);
            if (lat !== 3 || err !== 1'b0) bad_lat++;
            ref_commit(1'b1, A_CON, 16'h0041);
        end
        tests_run++;
        if (bad_lat !== 0) begin
            tests_failed++;
            $display("FAIL con_push_timing: got %0d bad accesses expected 0", bad_lat);
        end
        do_access(1'b0, A_STAT, 16'h0000, rd, err, lat, en, c0);
        tests_run++;
        if (rd !== 16'h0085 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL status_overflow: got %h err=%b expected 0085 0", rd, err);
        end
        do_access(1'b0, A_CON, 16'h0000, rd, err, lat, en, c0);
        tests_run++;
        if (rd !== 16'h0000 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL con_data_read: got %h err=%b expected 0000 0", rd, err);
        end
        p0 = pops;
        drain(dc);
        tests_run++;
        if (pops - p0 !== 8 || con_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL con_drain: got %0d pops valid=%b expected 8 0", pops - p0, con_valid);
        end
        do_access(1'b1, A_STAT, 16'h0004, rd, err, lat, en, c0);
        ref_commit(1'b1, A_STAT, 16'h0004);
        do_access(1'b0, A_STAT, 16'h0000, rd, err, lat, en, c0);
        tests_run++;
        if (rd !== 16'h0002) begin
            tests_failed++;
            $display("FAIL status_cleared: got %h expected 0002", rd);
        end
    endtask

    task automatic test_full_pop();
        logic [15:0] rd; logic err; int lat, en, c0, dc;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            do_access(1'b1, A_CON, 16'(8'h10 + i), rd, err, lat, en, c0);
            ref_commit(1'b1, A_CON, 16'(8'h10 + i));
        end
        @(negedge clk);
        cpu_if.req = 1'b1; cpu_if.write = 1'b1; cpu_if.addr = A_CON; cpu_if.wdata = 16'h0055;
        @(posedge clk); @(negedge clk); cpu_if.req = 1'b0;
        @(posedge clk); @(negedge clk); con_ready = 1'b1;
        @(posedge clk); @(negedge clk); con_ready = 1'b0;
        tests_run++;
        if (cpu_if.ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_pop_ready: got %b expected 1", cpu_if.ready);
        end
        ref_commit(1'b1, A_CON, 16'h0055);
        do_access(1'b0, A_STAT, 16'h0000, rd, err, lat, en, c0);
        tests_run++;
        if (rd !== 16'h0081 || rd !== ref_status()) begin
            tests_failed++;
            $display("FAIL full_pop_status: got %h expected 0081", rd);
        end
        drain(dc);
        tests_run++;
        if (fq.size() !== 0 || con_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_pop_drain: got model=%0d valid=%b expected 0 0", fq.size(), con_valid);
        end
    endtask

    task automatic test_console_random();
        logic [15:0] rd, exp; logic err; int lat, en, c0, dc;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            con_ready = ($urandom_range(0, 3) == 0);
            do_access(1'b1, A_CON, 16'($urandom), rd, err, lat, en, c0);
            ref_commit(1'b1, A_CON, cpu_if.wdata);
            if (i % 10 == 9) begin
                @(negedge clk); con_ready = 1'b0;
                exp = ref_status();
                do_access(1'b0, A_STAT, 16'h0000, rd, err, lat, en, c0);
                tests_run++;
                if (rd !== exp) begin
                    tests_failed++;
                    $display("FAIL rand_status: got %h expected %h", rd, exp);
                end
            end
        end
        do_access(1'b1, A_STAT, 16'h0004, rd, err, lat, en, c0);
        ref_commit(1'b1, A_STAT, 16'h0004);
        drain(dc);
        tests_run++;
        if (fq.size() !== 0 || con_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rand_drain: got model=%0d valid=%b expected 0 0", fq.size(), con_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd; logic err; int lat, en, c0, stray;
        stray = 0;
        @(negedge clk);
        cpu_if.req = 1'b1; cpu_if.write = 1'b1; cpu_if.addr = A_CON; cpu_if.wdata = 16'h0077;
        @(posedge clk); @(negedge clk); cpu_if.req = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        fq.delete();
        ovf_m = 1'b0;
        #1;
        tests_run++;
        if (out_vec() !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got %h expected %h", out_vec(), 64'h0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (cpu_if.ready !== 1'b0 || con_valid !== 1'b0) stray++;
        end
        tests_run++;
        if (stray !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid_stray: got %0d cycles with ready/valid expected 0", stray);
        end
        do_access(1'b0, A_STAT, 16'h0000, rd, err, lat, en, c0);
        tests_run++;
        if (rd !== 16'h0002) begin
            tests_failed++;
            $display("FAIL reset_mid_status: got %h expected 0002", rd);
        end
    endtask

    task automatic test_counter_wrap();
        logic [15:0] v1, v2; logic err; int lat, en, ca, cb, budget;
        do_access(1'b0, A_CYC, 16'h0000, v1, err, lat, en, ca);
        tests_run++;
        if (v1 !== 16'(ca + 1) || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL cycles_first: got %h err=%b expected %h 0", v1, err, 16'(ca + 1));
        end
        do_access(1'b1, A_CYC, 16'hAAAA, v2, err, lat, en, cb);
        tests_run++;
        if (err !== 1'b0 || lat !== 3) begin
            tests_failed++;
            $display("FAIL cycles_write: got err=%b lat=%0d expected 0 3", err, lat);
        end
        budget = 0;
        while (tb_cyc < 65541 && budget < 70000) begin
            @(posedge clk);
            budget++;
        end
        do_access(1'b0, A_CYC, 16'h0000, v2, err, lat, en, cb);
        tests_run++;
        if (v2 !== 16'(cb + 1)) begin
            tests_failed++;
            $display("FAIL cycles_second: got %h expected %h", v2, 16'(cb + 1));
        end
        tests_run++;
        if (16'(v2 - v1) !== 16'(cb - ca) || !(v2 < v1)) begin
            tests_failed++;
            $display("FAIL cycles_wrap: got v1=%h v2=%h diff=%h expected diff %h with wrap",
                     v1, v2, 16'(v2 - v1), 16'(cb - ca));
        end
    endtask

    initial begin
        cpu_if.req = 1'b0; cpu_if.write = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
        for (int i = 0; i < 4096; i++) begin
            ref_mem[i] = '0;
            tb_ram[i]  = '0;
        end
        test_reset();
        test_ram_rw();
        test_ram_random();
        test_unmapped();
        test_busy_ignore();
        test_console();
        test_full_pop();
        test_console_random();
        test_reset_mid();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
